// File: rtl/branch_writeback_arbiter_if.sv
// Result-stream bundle between execution branches, the writeback arbiter and the commit logic.
// The slave view belongs to the arbiter; the master view drives branch results and output ready.
interface branch_writeback_arbiter_if #(
  parameter int unsigned NBranches = 4,
  parameter int unsigned DataWidth = 16
);
  localparam int unsigned BranchW = (NBranches > 1) ? $clog2(NBranches) : 1;

  logic [NBranches-1:0]           in_valid;
  logic [NBranches-1:0]           in_ready;
  logic [NBranches*DataWidth-1:0] in_data;
  logic [NBranches*8-1:0]         in_res_addr;
  logic [NBranches*9-1:0]         in_commit_id;
  logic [NBranches-1:0]           in_commit_flag;
  logic [NBranches-1:0]           in_writes_external;

  logic                           out_valid;
  logic                           out_ready;
  logic [DataWidth-1:0]           out_data;
  logic [7:0]                     out_res_addr;
  logic [8:0]                     out_commit_id;
  logic                           out_commit_flag;
  logic                           out_writes_external;
  logic [BranchW-1:0]             out_branch;

  modport slave (
    input  in_valid, in_data, in_res_addr, in_commit_id, in_commit_flag, in_writes_external,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_res_addr, out_commit_id, out_commit_flag,
    output out_writes_external, out_branch
  );

  modport master (
    output in_valid, in_data, in_res_addr, in_commit_id, in_commit_flag, in_writes_external,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_res_addr, out_commit_id, out_commit_flag,
    input  out_writes_external, out_branch
  );
endinterface

// File: rtl/branch_writeback_arbiter.sv
// Round-robin merge of per-branch results into one registered writeback slot,
// with a saturating retire counter latched on each sample tick.
module branch_writeback_arbiter #(
  parameter int unsigned NBranches = 4,
  parameter int unsigned DataWidth = 16,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_sample_tick,
  branch_writeback_arbiter_if.slave bus,
  output logic                    o_busy,
  output logic [CntWidth-1:0]     o_retire_count
);
  localparam int unsigned BranchW = (NBranches > 1) ? $clog2(NBranches) : 1;

  logic [BranchW-1:0]   r_rr_ptr;
  logic [BranchW-1:0]   w_grant;
  logic [BranchW-1:0]   w_rr_next;
  int unsigned          w_grant_idx;
  logic                 w_found;
  logic                 w_slot_free;
  logic                 w_take_in;
  logic                 w_take_out;

  logic                 r_out_valid;
  logic [DataWidth-1:0] r_out_data;
  logic [7:0]           r_out_res_addr;
  logic [8:0]           r_out_commit_id;
  logic                 r_out_commit_flag;
  logic                 r_out_writes_external;
  logic [BranchW-1:0]   r_out_branch;

  logic [CntWidth-1:0]  r_run_cnt;
  logic [CntWidth-1:0]  w_run_sat;
  logic [CntWidth-1:0]  r_retire_count;

  // Circular search starting at the round-robin pointer; first valid branch wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_grant_idx = 0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < NBranches; k++) begin
      idx = (32'(r_rr_ptr) + k) % NBranches;
      if (!w_found && bus.in_valid[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = idx;
      end
    end
  end

  assign w_grant     = BranchW'(w_grant_idx);
  assign w_rr_next   = (w_grant_idx == NBranches - 1) ? '0 : BranchW'(w_grant_idx + 1);
  assign w_slot_free = ~r_out_valid | bus.out_ready;
  assign w_take_in   = i_enable & w_slot_free & w_found;
  assign w_take_out  = r_out_valid & bus.out_ready;

  always_comb begin
    bus.in_ready = '0;
    if (w_take_in) begin
      bus.in_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid           <= 1'b0;
      r_out_data            <= '0;
      r_out_res_addr        <= '0;
      r_out_commit_id       <= '0;
      r_out_commit_flag     <= 1'b0;
      r_out_writes_external <= 1'b0;
      r_out_branch          <= '0;
      r_rr_ptr              <= '0;
    end else if (w_take_in) begin
      r_out_valid           <= 1'b1;
      r_out_data            <= bus.in_data[w_grant_idx*DataWidth +: DataWidth];
      r_out_res_addr        <= bus.in_res_addr[w_grant_idx*8 +: 8];
      r_out_commit_id       <= bus.in_commit_id[w_grant_idx*9 +: 9];
      r_out_commit_flag     <= bus.in_commit_flag[w_grant_idx];
      r_out_writes_external <= bus.in_writes_external[w_grant_idx];
      r_out_branch          <= w_grant;
      r_rr_ptr              <= w_rr_next;
    end else if (w_take_out) begin
      r_out_valid           <= 1'b0;
    end
  end

  // The tick captures the count including this cycle's handshake.
  assign w_run_sat = (w_take_out && (r_run_cnt != '1)) ? r_run_cnt + CntWidth'(1) : r_run_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt      <= '0;
      r_retire_count <= '0;
    end else if (i_sample_tick) begin
      r_run_cnt      <= '0;
      r_retire_count <= w_run_sat;
    end else begin
      r_run_cnt      <= w_run_sat;
    end
  end

  assign bus.out_valid           = r_out_valid;
  assign bus.out_data            = r_out_data;
  assign bus.out_res_addr        = r_out_res_addr;
  assign bus.out_commit_id       = r_out_commit_id;
  assign bus.out_commit_flag     = r_out_commit_flag;
  assign bus.out_writes_external = r_out_writes_external;
  assign bus.out_branch          = r_out_branch;

  assign o_busy         = r_out_valid | (|bus.in_valid);
  assign o_retire_count = r_retire_count;
endmodule

// File: doc/branch_writeback_arbiter.md
Name: branch_writeback_arbiter

Overview:
Merges the per-branch result streams of the instruction execution branches into the single writeback/commit port. It sits downstream of the branch router and the per-branch execution units and feeds the register/commit logic. It arbitrates round-robin between branches with a one-entry registered output stage and valid/ready on every port. It also counts retired results per sample period for status/debug readout.

Parameters:
n_branches, 4, number of requesting execution branches (>= 2)
data_width, 16, width of the result data word
cnt_width, 16, width of the per-sample retire counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  when low, no new results are accepted; the output stage may still drain
sample_tick  in  1  one-cycle pulse marking a sample-period boundary
in_valid  in  n_branches  per-branch result valid
in_ready  out  n_branches  per-branch accept; combinational
in_data  in  n_branches*data_width  result words; branch i at [i*data_width +: data_width]
in_res_addr  in  n_branches*8  result/register addresses
in_commit_id  in  n_branches*9  commit ids
in_commit_flag  in  n_branches  commit flags
in_writes_external  in  n_branches  external-write flags
out_valid  out  1  output stage holds a result
out_ready  in  1  downstream accept
out_data  out  data_width  registered result word
out_res_addr  out  8  registered address
out_commit_id  out  9  registered commit id
out_commit_flag  out  1  registered commit flag
out_writes_external  out  1  registered external-write flag
out_branch  out  $clog2(n_branches)  index of the branch that produced the output
busy  out  1  out_valid | (|in_valid)
retire_count  out  cnt_width  output handshakes counted in the last completed sample period

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, all payload outputs=0, out_branch=0, rr_ptr=0, run counter=0, retire_count=0.
- slot_free = ~out_valid | out_ready.
- Grant: combinational. The winner is the first index with in_valid set, searching circularly from rr_ptr (rr_ptr, rr_ptr+1, ... mod n_branches).
- in_ready[g] = enable & slot_free, for the winner g only. All other in_ready bits are 0. If no in_valid bit is set, all in_ready bits are 0.
- take_in = enable & slot_free & (|in_valid). On take_in:
  - The output registers load branch g's fields.
  - out_branch <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod n_branches. The wrap from n_branches-1 goes to 0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 result per cycle when out_ready is held high, including load and drain in the same cycle.
- take_out = out_valid & out_ready. If take_out and no take_in, then out_valid <= 0.
- Hold rule: while out_valid=1 and out_ready=0, all out_* signals are stable and in_ready=0.
- Fairness: a branch whose in_valid is held is granted within n_branches accepts.
- enable=0: no accepts, and rr_ptr is frozen. A pending output still completes on out_ready.
- Retire counting:
  - The run counter increments on each take_out and saturates at 2^cnt_width-1.
  - On sample_tick, retire_count <= run counter value including the current cycle's take_out (saturated).
  - On the same sample_tick, the run counter <= 0.
- The arbiter does not check payloads. Commit-id ordering is the commit logic's responsibility.
- Reset asserted mid-transfer discards the held output without a handshake.

Test Plan:
- Single branch 2 valid with data=0x1234, addr=0x05, id=0x101, out_ready=1 -> in_ready=0b0100; next cycle out_valid=1, out_data=0x1234, out_commit_id=0x101, out_branch=2; rr_ptr=3.
- All 4 branches valid continuously, out_ready=1, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; one output per cycle.
- Output held with out_ready=0 for 5 cycles while branches 1 and 3 are valid -> out_* stable, in_ready=0; on release, branch 1 is granted in the same cycle as the drain.
- rr_ptr=3 with only branch 0 valid -> branch 0 is granted (wrap) and rr_ptr becomes 1.
- 7 output handshakes, then sample_tick in a cycle that also has a handshake -> retire_count=8 and the counter restarts from 0.
- enable=0 with out_valid=1 and all in_valid=1 -> the output drains on out_ready and no new accept occurs. Then assert reset=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately, retire_count=0.
